// File: rtl/pp_pkg.sv
// pp_pkg: shared widths and constants for the partial-product summing pipeline.
package pp_pkg;
    localparam int PP_W       = 16;
    localparam int PIPE_DEPTH = 2;
    localparam int PP_SHIFT [4] = '{0, 2, 4, 6};
    localparam int CNT_W      = 16;
endpackage

// File: rtl/pp_add_stage.sv
// pp_add_stage: one registered modulo-2^W adder with a valid/ready handshake.
module pp_add_stage
    import pp_pkg::*;
#(
    parameter int W = PP_W
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum
);
    assign in_ready = !out_valid || out_ready;
    // When loading with in_valid low a bubble moves in, but the sum keeps its value
    always_ff @(posedge clk) begin
        if (clr) begin
            out_valid <= 1'b0;
            sum       <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) sum <= a + b;
        end
    end
endmodule

// File: rtl/pp_sum_pipe.sv
// pp_sum_pipe: two-stage pipelined sum of four partial products into a signed 8x8 product.
// Optional transfer counter output prod_cnt is enabled with macro PP_SUM_CNT_EN.
module pp_sum_pipe
    import pp_pkg::*;
#(
    parameter int PP_W = pp_pkg::PP_W
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PP_W-1:0] pp0,
    input  logic [PP_W-1:0] pp1,
    input  logic [PP_W-1:0] pp2,
    input  logic [PP_W-1:0] pp3,
    output logic            out_valid,
    input  logic            out_ready,
`ifdef PP_SUM_CNT_EN
    output logic [CNT_W-1:0] prod_cnt,
`endif
    output logic [PP_W-1:0] prod
);
    logic            v01, v23, r01, r23, s1_valid, s2_ready;
    logic [PP_W-1:0] s01, s23;
    // Both stage-1 adders share the handshake, so their valid/ready always agree
    assign s1_valid = v01 && v23;
    assign in_ready = r01 && r23;
    pp_add_stage #(.W(PP_W)) u_s01 (
        .clk, .clr, .in_valid, .in_ready(r01), .a(pp0), .b(pp1),
        .out_valid(v01), .out_ready(s2_ready), .sum(s01)
    );
    pp_add_stage #(.W(PP_W)) u_s23 (
        .clk, .clr, .in_valid, .in_ready(r23), .a(pp2), .b(pp3),
        .out_valid(v23), .out_ready(s2_ready), .sum(s23)
    );
    pp_add_stage #(.W(PP_W)) u_s2 (
        .clk, .clr, .in_valid(s1_valid), .in_ready(s2_ready), .a(s01), .b(s23),
        .out_valid, .out_ready, .sum(prod)
    );
`ifdef PP_SUM_CNT_EN
    always_ff @(posedge clk) begin
        if (clr) prod_cnt <= '0;
        else if (out_valid && out_ready) prod_cnt <= prod_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_pp_sum_pipe.sv
// tb_pp_sum_pipe: directed and random checks of pp_sum_pipe against a queue-based sum model.
module tb_pp_sum_pipe;
    logic        clk = 0, clr = 1, in_valid = 0, out_ready = 1;
    logic        in_ready, out_valid;
    logic [15:0] pp0 = 0, pp1 = 0, pp2 = 0, pp3 = 0, prod, held;
    int          checks = 0, errors = 0, outs = 0, ncyc = 0;
    logic [63:0] pend[$];
    logic [15:0] exp_q[$];
`ifdef PP_SUM_CNT_EN
    logic [15:0] prod_cnt;
    int          cnt_exp = 0;
`endif

    always #5 clk = ~clk;

    pp_sum_pipe dut (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .pp0(pp0), .pp1(pp1), .pp2(pp2), .pp3(pp3),
        .out_valid(out_valid), .out_ready(out_ready),
`ifdef PP_SUM_CNT_EN
        .prod_cnt(prod_cnt),
`endif
        .prod(prod)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Partial products of a*b: radix-4 digits of b, top digit signed
    function automatic logic [63:0] gen(input int a, input int b);
        logic [63:0] v;
        int d;
        for (int i = 0; i < 4; i++) begin
            d = (i == 3) ? (b >>> 6) : ((b >> (2 * i)) & 3);
            v[16*i +: 16] = 16'((a * d) << (2 * i));
        end
        return v;
    endfunction

    function automatic logic [15:0] ref_sum(input logic [63:0] v);
        return v[15:0] + v[31:16] + v[47:32] + v[63:48];
    endfunction

    task automatic cyc(input string tag);
        logic acc;
        in_valid = pend.size() > 0;
        if (in_valid) {pp3, pp2, pp1, pp0} = pend[0];
        #1;
        acc = !clr && in_valid && in_ready;
        if (!clr && out_valid && out_ready) begin
            chk({tag, " result expected"}, 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk({tag, " prod"}, 32'(prod), 32'(exp_q.pop_front()));
            outs++;
`ifdef PP_SUM_CNT_EN
            cnt_exp++;
`endif
        end
        @(posedge clk);
        ncyc++;
        if (acc) exp_q.push_back(ref_sum(pend.pop_front()));
        if (clr) begin
            exp_q.delete();
`ifdef PP_SUM_CNT_EN
            cnt_exp = 0;
`endif
        end
        #1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60 && (pend.size() != 0 || exp_q.size() != 0); i++) cyc(tag);
        chk({tag, " drained"}, 32'(pend.size() + exp_q.size()), 32'd0);
    endtask

    task automatic wait_out(input string tag, input logic [15:0] exp);
        for (int i = 0; i < 10 && !out_valid; i++) cyc(tag);
        chk({tag, " valid"}, 32'(out_valid), 32'd1);
        chk({tag, " value"}, 32'(prod), 32'(exp));
        drain(tag);
    endtask

    initial begin
        clr = 1;
        cyc("rst");
        cyc("rst");
        clr = 0;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst prod", 32'(prod), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
`ifdef PP_SUM_CNT_EN
        chk("rst cnt", 32'(prod_cnt), 32'd0);
`endif

        pend.push_back({16'h0100, 16'h0010, 16'h0004, 16'h0003});
        chk("basic c0 valid", 32'(out_valid), 32'd0);
        cyc("basic");
        chk("basic c1 valid", 32'(out_valid), 32'd0);
        cyc("basic");
        chk("basic c2 valid", 32'(out_valid), 32'd1);
        chk("basic c2 prod", 32'(prod), 32'h0117);
        drain("basic");

        pend.push_back(gen(-128, -128));
        wait_out("neg128", 16'h4000);
        pend.push_back(gen(5, -3));
        wait_out("neg5x3", 16'hFFF1);

        pend.push_back({16'h0000, 16'h0000, 16'h0001, 16'hFFFF});
        wait_out("wrap", 16'h0000);
        chk("wrap in_ready", 32'(in_ready), 32'd1);

        out_ready = 0;
        for (int i = 0; i < 3; i++) pend.push_back({$urandom, $urandom});
        cyc("bp");
        cyc("bp");
        chk("bp in_ready low", 32'(in_ready), 32'd0);
        chk("bp accepted", 32'(exp_q.size()), 32'd2);
        held = prod;
        chk("bp first result", 32'(prod), 32'(exp_q[0]));
        cyc("bp");
        cyc("bp");
        chk("bp prod stable", 32'(prod), 32'(held));
        chk("bp valid stable", 32'(out_valid), 32'd1);
        chk("bp still pending", 32'(pend.size()), 32'd1);
        out_ready = 1;
        outs = 0;
        drain("bp");
        chk("bp outputs", 32'(outs), 32'd3);

        out_ready = 0;
        for (int i = 0; i < 3; i++) pend.push_back({$urandom, $urandom});
        cyc("mid");
        cyc("mid");
        clr = 1;
        cyc("mid");
        clr = 0;
        chk("mid out_valid", 32'(out_valid), 32'd0);
        chk("mid prod", 32'(prod), 32'd0);
        chk("mid in_ready", 32'(in_ready), 32'd1);
`ifdef PP_SUM_CNT_EN
        chk("mid cnt", 32'(prod_cnt), 32'd0);
`endif
        pend.delete();
        out_ready = 1;
        cyc("mid");
        cyc("mid");
        chk("mid no stale", 32'(out_valid), 32'd0);

        for (int i = 0; i < 20; i++)
            pend.push_back(gen(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128));
        outs = 0;
        ncyc = 0;
        drain("stream");
        chk("stream outputs", 32'(outs), 32'd20);
        chk("stream cycles", 32'(ncyc), 32'd22);
`ifdef PP_SUM_CNT_EN
        chk("stream cnt", 32'(prod_cnt), 32'(cnt_exp));
        chk("stream cnt abs", 32'(prod_cnt), 32'd20);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
